// File: rtl/bram_lane_pipe_pkg.sv
// rtl/bram_lane_pipe_pkg.sv - shared constants, clear FSM states and lane merge helper
package bram_pkg;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;
  localparam int MAX_DATA_WIDTH  = 256;
  localparam int MAX_LANES       = 32;

  typedef enum logic {
    IDLE,
    CLEAR
  } clearState_e;

  // Sized for the widest supported word so one helper serves every instance; callers truncate.
  function automatic logic [MAX_DATA_WIDTH-1:0] lane_merge(
    input logic [MAX_DATA_WIDTH-1:0] oldWord,
    input logic [MAX_DATA_WIDTH-1:0] newWord,
    input logic [MAX_LANES-1:0]      mask,
    input int                        laneWidth
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    logic [4:0]                lane;
    merged = oldWord;
    for (int b = 0; b < MAX_DATA_WIDTH; b++) begin
      lane = 5'(b / laneWidth);
      if ((b < laneWidth * MAX_LANES) && mask[lane]) merged[b] = newWord[b];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bram_lane_pipe_if.sv
// rtl/bram_lane_pipe_if.sv - read/write/clear port bundle for bram_lane_pipe
interface bram_lane_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANE_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;

  logic                  readEnable;
  logic [ADDR_WIDTH-1:0] readAddress;
  logic [DATA_WIDTH-1:0] readData;
  logic                  readValid;
  logic                  writeEnable;
  logic [ADDR_WIDTH-1:0] writeAddress;
  logic [NUM_LANES-1:0]  writeMask;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  clearRequest;
  logic                  busy;

  modport master (
    output readEnable, readAddress, writeEnable, writeAddress, writeMask, writeData, clearRequest,
    input  readData, readValid, busy
  );

  modport slave (
    input  readEnable, readAddress, writeEnable, writeAddress, writeMask, writeData, clearRequest,
    output readData, readValid, busy
  );
endinterface

// File: rtl/bram_lane_pipe_clear_fsm.sv
// rtl/bram_lane_pipe_clear_fsm.sv - sweeps zeros through the whole array after reset or on request
module bram_clear_fsm
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clearRequest,
  output logic                  busy,
  output logic                  clearWrite,
  output logic [ADDR_WIDTH-1:0] clearAddress
);

  clearState_e           state, stateNext;
  logic [ADDR_WIDTH-1:0] counter, counterNext;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      counter <= '0;
    end else begin
      state   <= stateNext;
      counter <= counterNext;
    end
  end

  always_comb begin
    stateNext   = state;
    counterNext = counter;
    case (state)
      IDLE: begin
        if (clearRequest) begin
          stateNext   = CLEAR;
          counterNext = '0;
        end
      end
      CLEAR: begin
        // Counter wraps to zero on the final write, leaving it ready for the next sweep.
        counterNext = counter + ADDR_WIDTH'(1);
        if (counter == '1) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy         = (state == CLEAR);
  assign clearWrite   = busy;
  assign clearAddress = counter;

endmodule

// File: rtl/bram_lane_pipe.sv
// rtl/bram_lane_pipe.sv - lane-masked dual-port RAM with 1/2-cycle read pipeline and clear engine
module bram_lane_pipe
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int LANE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic             clock,
  input logic             resetn,
  bram_lane_pipe_if.slave bus
);

  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : gBadLatency
    $error("bram_lane_pipe: READ_LATENCY must be 1 or 2");
  end
  if (NUM_LANES * LANE_WIDTH != DATA_WIDTH) begin : gBadLanes
    $error("bram_lane_pipe: DATA_WIDTH must be a multiple of LANE_WIDTH");
  end
  if (RDW_MODE != RDW_WRITE_FIRST && RDW_MODE != RDW_READ_FIRST) begin : gBadRdw
    $error("bram_lane_pipe: RDW_MODE must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] ram [MEM_DEPTH];

  logic                  busy;
  logic                  clearWrite;
  logic [ADDR_WIDTH-1:0] clearAddress;

  bram_clear_fsm #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) clearFsm (
    .clock       (clock),
    .resetn      (resetn),
    .clearRequest(bus.clearRequest),
    .busy        (busy),
    .clearWrite  (clearWrite),
    .clearAddress(clearAddress)
  );

  logic                  writeAccept;
  logic                  readAccept;
  logic [DATA_WIDTH-1:0] readOld;
  logic [DATA_WIDTH-1:0] writeOld;
  logic [DATA_WIDTH-1:0] mergedWrite;
  logic [DATA_WIDTH-1:0] readWord;

  assign writeAccept = bus.writeEnable & ~busy & (|bus.writeMask);
  assign readAccept  = bus.readEnable & ~busy;
  assign readOld     = ram[bus.readAddress];
  assign writeOld    = ram[bus.writeAddress];
  assign mergedWrite = DATA_WIDTH'(lane_merge(MAX_DATA_WIDTH'(writeOld), MAX_DATA_WIDTH'(bus.writeData),
                                              MAX_LANES'(bus.writeMask), LANE_WIDTH));

  // Write-first forwards the merged word so a colliding read sees the update immediately.
  assign readWord = (RDW_MODE == RDW_WRITE_FIRST && writeAccept && bus.readAddress == bus.writeAddress)
                  ? mergedWrite : readOld;

  always_ff @(posedge clock) begin
    if (clearWrite) ram[clearAddress] <= '0;
    else if (writeAccept) ram[bus.writeAddress] <= mergedWrite;
  end

  logic [DATA_WIDTH-1:0] stage1Data;
  logic                  stage1Valid;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stage1Data  <= '0;
      stage1Valid <= 1'b0;
    end else begin
      stage1Data  <= readAccept ? readWord : '0;
      stage1Valid <= readAccept;
    end
  end

  if (READ_LATENCY == 2) begin : gTwoStage
    logic [DATA_WIDTH-1:0] stage2Data;
    logic                  stage2Valid;

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        stage2Data  <= '0;
        stage2Valid <= 1'b0;
      end else begin
        stage2Data  <= stage1Data;
        stage2Valid <= stage1Valid;
      end
    end

    assign bus.readData  = stage2Data;
    assign bus.readValid = stage2Valid;
  end else begin : gOneStage
    assign bus.readData  = stage1Data;
    assign bus.readValid = stage1Valid;
  end

  assign bus.busy = busy;

endmodule

// File: doc/bram_lane_pipe.md
Name: bram_lane_pipe

Overview:
- Parametrised successor to the team's simple dual-port block RAM: one write port and one read port on a single clock.
- Adds per-lane write masking, a selectable 1- or 2-cycle read latency with a `readValid` strobe, and a selectable read-during-write mode.
- Adds a built-in clear engine that zeroes the whole array after reset or on request.
- Used for the layer-multiplexed NN weight, activation and error stores, where partial-word updates and deterministic initial contents are required.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8, bits per write-mask lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
- ADDR_WIDTH, 8, address width; MEM_DEPTH = 1<<ADDR_WIDTH.
- READ_LATENCY, 1, 1 or 2 cycles from readEnable to readData/readValid; other values are an elaboration error.
- RDW_MODE, 0, read-during-write to the same address: 0 = write-first (new merged data), 1 = read-first (old data).
- CLEAR_ON_RESET, 1, 1 = run the clear engine automatically after reset deassertion.

Ports:
- clock  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- readEnable  input  1  read request, sampled each cycle.
- readAddress  input  ADDR_WIDTH  read address.
- readData  output  DATA_WIDTH  read data, registered.
- readValid  output  1  high exactly when readData carries an accepted read.
- writeEnable  input  1  write request.
- writeAddress  input  ADDR_WIDTH  write address.
- writeMask  input  NUM_LANES  lane i writes bits [i*LANE_WIDTH +: LANE_WIDTH]; all-zero mask means no write.
- writeData  input  DATA_WIDTH  write data.
- clearRequest  input  1  single-cycle pulse that starts a full-array clear.
- busy  output  1  clear engine active; all port requests are ignored while high.

Behaviour:
- Reset (resetn low): readData=0, readValid=0, pipeline stage registers=0, clear counter=0.
  - FSM resets to CLEAR with busy=1 if CLEAR_ON_RESET=1; otherwise to IDLE with busy=0.
  - Array contents are not reset asynchronously.
- FSM states:
  - IDLE: clearRequest=1 -> CLEAR, counter=0, busy=1 from the next cycle.
  - CLEAR: writes 0 to ram[counter] each cycle and increments counter. At counter==MEM_DEPTH-1, performs the final write and goes to IDLE, so busy drops after exactly MEM_DEPTH cycles in CLEAR.
  - clearRequest during CLEAR is ignored (no restart).
- Accepted operations: a write is accepted when writeEnable & !busy & |writeMask; a read is accepted when readEnable & !busy.
  - Requests presented while busy are dropped with no queuing and no readValid.
- Write: on accepted write, only the masked lanes of ram[writeAddress] are updated at the clock edge.
- Read, READ_LATENCY=1: readData/readValid are updated at the edge after acceptance.
- Read, READ_LATENCY=2: one extra output register stage; readValid is delayed to match. Back-to-back reads give one result per cycle.
- Output on non-accepted read cycles: readData=0 and readValid=0 at the corresponding output cycle.
- Read-during-write (same cycle, same address, both accepted):
  - RDW_MODE=0: returned word = old word with masked lanes replaced by writeData.
  - RDW_MODE=1: returned word = old word.
- A read issued the cycle after a write to the same address always returns the new contents.
- Reset asserted mid-read: in-flight data is discarded and readValid=0.
- Reset asserted mid-clear: the counter returns to 0; with CLEAR_ON_RESET=1 the clear restarts from address 0 after release.

Decomposition:
- Shared package `bram_pkg`:
  - RDW_WRITE_FIRST=0 and RDW_READ_FIRST=1 constants.
  - Clear FSM state typedef (IDLE, CLEAR).
  - `lane_merge` function (old, new, mask -> merged word).
- One sub-module, `bram_clear_fsm`: state, counter, busy, and the clear write address/enable.
- The array, port muxing and read pipeline stay in the top module.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> busy high for exactly 16 cycles. Reads of addresses 0..15 then return 0 with readValid=1 one cycle later.
- Write 0xAABBCCDD to addr 3 with mask 4'b1111, then write 0x11223344 with mask 4'b0101 -> read addr 3 returns 0xAA22CC44.
- RDW_MODE=0 vs 1: addr 5 holds 0x0; same-cycle write 0xFFFFFFFF (mask 1111) and read of addr 5 -> mode 0 returns 0xFFFFFFFF, mode 1 returns 0x0. Both modes return 0xFFFFFFFF on the next read.
- READ_LATENCY=2: reads of addrs 1,2,3 on consecutive cycles -> readValid high on cycles +2,+3,+4 with data in order. Idle cycle -> readData=0, readValid=0.
- clearRequest with data present, plus writeEnable/readEnable asserted during busy -> requests dropped, no readValid. After busy falls, all locations read 0.
- resetn pulsed low at clear counter=7 -> busy stays high and the clear restarts. Total busy after release = MEM_DEPTH cycles; an in-flight read's readValid is suppressed.
